// File: rtl/wb_cmd_pkg.sv
// wb_cmd_pkg: command/status codes and FSM states shared by wb_cmd_master
package wb_cmd_pkg;
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_ERR     = 8'h01;
    localparam logic [7:0] ST_TIMEOUT = 8'h02;
    localparam logic [7:0] ST_BADCMD  = 8'hFF;
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS_REQ, BUS_WAIT, RESP_STAT, RESP_DATA} state_e;
endpackage

// File: rtl/wb_if.sv
// wb_if: pipelined Wishbone B4 bus signals with master/slave views
interface wb_if;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_m, dat_s;
    logic        ack, err, stall;
    modport master(output cyc, stb, we, sel, adr, dat_m, input dat_s, ack, err, stall);
    modport slave(input cyc, stb, we, sel, adr, dat_m, output dat_s, ack, err, stall);
endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: byte-stream command decoder driving one Wishbone master transaction per frame
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int BUS_TIMEOUT   = 1024,
    parameter int FRAME_TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    wb_if.master       wb
);
    localparam int BW = $clog2(BUS_TIMEOUT + 1);
    localparam int FW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [BW-1:0] BUS_LAST   = BW'(BUS_TIMEOUT - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TIMEOUT - 1);

    state_e        state;
    logic          is_read;
    logic [1:0]    bcnt;
    logic [31:0]   rdata;
    logic [BW-1:0] bus_cnt;
    logic [FW-1:0] frame_cnt;
    logic          rx_fire, tx_fire, bus_resp;

    assign rx_ready = state inside {IDLE, ADDR, WDATA};
    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;
    // a response while the request is still stalled cannot belong to it
    assign bus_resp = (state == BUS_WAIT || !wb.stall) && (wb.ack || wb.err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            is_read   <= 1'b0;
            bcnt      <= '0;
            rdata     <= '0;
            bus_cnt   <= '0;
            frame_cnt <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            wb.cyc    <= 1'b0;
            wb.stb    <= 1'b0;
            wb.we     <= 1'b0;
            wb.sel    <= '0;
            wb.adr    <= '0;
            wb.dat_m  <= '0;
        end else begin
            case (state)
                IDLE: if (rx_fire) begin
                    bcnt      <= '0;
                    frame_cnt <= '0;
                    is_read   <= rx_data == CMD_READ;
                    if (rx_data == CMD_READ || rx_data == CMD_WRITE) state <= ADDR;
                    else begin
                        state    <= RESP_STAT;
                        tx_valid <= 1'b1;
                        tx_data  <= ST_BADCMD;
                    end
                end
                ADDR, WDATA: begin
                    if (rx_fire) begin
                        frame_cnt <= '0;
                        bcnt      <= bcnt + 1'b1;
                        if (state == ADDR) wb.adr <= {rx_data, wb.adr[31:8]};
                        else wb.dat_m <= {rx_data, wb.dat_m[31:8]};
                        if (bcnt == 2'd3) begin
                            if (state == ADDR && !is_read) state <= WDATA;
                            else begin
                                state   <= BUS_REQ;
                                wb.cyc  <= 1'b1;
                                wb.stb  <= 1'b1;
                                wb.we   <= !is_read;
                                wb.sel  <= 4'hF;
                                bus_cnt <= '0;
                            end
                        end
                    end else if (frame_cnt == FRAME_LAST) state <= IDLE;
                    else frame_cnt <= frame_cnt + 1'b1;
                end
                BUS_REQ, BUS_WAIT: begin
                    bus_cnt <= bus_cnt + 1'b1;
                    if (state == BUS_REQ && !wb.stall) begin
                        wb.stb <= 1'b0;
                        state  <= BUS_WAIT;
                    end
                    if (bus_resp || bus_cnt == BUS_LAST) begin
                        wb.cyc   <= 1'b0;
                        wb.stb   <= 1'b0;
                        state    <= RESP_STAT;
                        tx_valid <= 1'b1;
                        tx_data  <= !bus_resp ? ST_TIMEOUT : wb.ack ? ST_OK : ST_ERR;
                        rdata    <= bus_resp && wb.ack ? wb.dat_s : '0;
                    end
                end
                RESP_STAT: if (tx_fire) begin
                    if (is_read && (tx_data == ST_OK || tx_data == ST_TIMEOUT)) begin
                        state   <= RESP_DATA;
                        bcnt    <= '0;
                        tx_data <= rdata[7:0];
                        rdata   <= {8'h00, rdata[31:8]};
                    end else begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                    end
                end
                RESP_DATA: if (tx_fire) begin
                    bcnt <= bcnt + 1'b1;
                    if (bcnt == 2'd3) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                    end else begin
                        tx_data <= rdata[7:0];
                        rdata   <= {8'h00, rdata[31:8]};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: randomized frames against a frame-level model, with a reactive RAM slave
module tb_wb_cmd_master;
    localparam int M_OK = 0, M_ERR = 1, M_NORESP = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;

    wb_if wb();

    wb_cmd_master #(.BUS_TIMEOUT(16), .FRAME_TIMEOUT(50)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb(wb)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cfg_mode = M_OK, cfg_stall = 0, cfg_lat = 0, tx_block = 0;
    int stb_seen = 0, acc_age = -1, cyc_rises = 0, cyc_len = 0, stb_len = 0;
    int stable_viol = 0, hold_viol = 0;
    logic        acc_we, prev_cyc = 1'b0, prev_v = 1'b0, prev_r = 1'b0;
    logic [3:0]  acc_sel;
    logic [31:0] acc_adr, acc_dat, rise_adr, rise_dat;
    logic [7:0]  prev_d;
    logic [31:0] slave_mem[16], model_mem[16];
    logic [7:0]  got_q[$], exp_q[$];

    // Slave, bus monitor and tx sink all act on the falling edge, away from DUT updates
    always @(negedge clk) begin
        if (prev_v && !prev_r && (!tx_valid || tx_data !== prev_d)) hold_viol++;
        tx_ready = tx_block > 0 ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (tx_block > 0) tx_block--;
        if (tx_valid && tx_ready) got_q.push_back(tx_data);
        prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data;
        if (wb.cyc && !prev_cyc) begin
            cyc_rises++; cyc_len = 0; stb_len = 0; rise_adr = wb.adr; rise_dat = wb.dat_m;
        end
        if (wb.cyc) begin
            cyc_len++;
            if (wb.stb) stb_len++;
            if (wb.adr !== rise_adr || wb.dat_m !== rise_dat) stable_viol++;
        end
        prev_cyc = wb.cyc;
        wb.ack = 1'b0; wb.err = 1'b0; wb.stall = 1'b0;
        if (!wb.cyc) begin
            stb_seen = 0; acc_age = -1;
        end else begin
            if (wb.stb) begin
                wb.stall = stb_seen < cfg_stall;
                stb_seen++;
                if (!wb.stall) begin
                    acc_age = 0; acc_adr = wb.adr; acc_we = wb.we; acc_dat = wb.dat_m; acc_sel = wb.sel;
                end
            end else if (acc_age >= 0) acc_age++;
            if (acc_age == cfg_lat && cfg_mode != M_NORESP) begin
                wb.ack = cfg_mode == M_OK;
                wb.err = cfg_mode == M_ERR;
                if (wb.ack && acc_we) slave_mem[acc_adr[5:2]] = acc_dat;
            end
        end
        wb.dat_s = wb.ack ? slave_mem[acc_adr[5:2]] : $urandom;
    end

    function automatic logic [39:0] pk(input logic [7:0] q[$]);
        logic [39:0] r;
        r = '0;
        foreach (q[i]) if (i < 5) r[i*8 +: 8] = q[i];
        return r;
    endfunction

    // Expected response bytes of one frame, from the command and slave behaviour alone
    task automatic model_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d, input int mode);
        exp_q = {};
        if (cmd != 8'h01 && cmd != 8'h02) exp_q.push_back(8'hFF);
        else if (mode == M_ERR) exp_q.push_back(8'h01);
        else if (mode == M_NORESP) begin
            exp_q.push_back(8'h02);
            if (cmd == 8'h02) repeat (4) exp_q.push_back(8'h00);
        end else begin
            exp_q.push_back(8'h00);
            if (cmd == 8'h01) model_mem[a[5:2]] = d;
            else for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[a[5:2]][i*8 +: 8]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(negedge clk);
        while (!rx_ready && n < 500) begin @(negedge clk); n++; end
        if (!rx_ready) begin
            checks++; errors++;
            $display("FAIL rx_ready_wait: rx_ready=%b after %0d cycles, expected 1", rx_ready, n);
        end
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
        send_byte(cmd);
        if (cmd == 8'h01 || cmd == 8'h02) begin
            for (int i = 0; i < 4; i++) send_byte(a[i*8 +: 8]);
            if (cmd == 8'h01) for (int i = 0; i < 4; i++) send_byte(d[i*8 +: 8]);
        end
    endtask

    task automatic wait_resp(input int n);
        int k = 0;
        while (!(rx_ready && !tx_valid && got_q.size() >= n) && k < 400) begin @(posedge clk); #1; k++; end
        if (k >= 400) begin
            checks++; errors++;
            $display("FAIL resp_wait: %0d bytes after %0d cycles, expected %0d then idle", got_q.size(), k, n);
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d, input int mode);
        cfg_mode = mode;
        got_q = {};
        model_frame(cmd, a, d, mode);
        send_frame(cmd, a, d);
        wait_resp(exp_q.size());
    endtask

    task automatic test_reset;
        #3 rst_n = 1'b0;
        #1;
        checks += 5;
        if ({wb.cyc, wb.stb, wb.we, wb.sel} !== 7'd0) begin errors++; $display("FAIL reset_ctrl: cyc/stb/we/sel=%b, expected 0", {wb.cyc, wb.stb, wb.we, wb.sel}); end
        if (wb.adr !== 32'd0) begin errors++; $display("FAIL reset_adr: got %h, expected 0", wb.adr); end
        if (wb.dat_m !== 32'd0) begin errors++; $display("FAIL reset_dat_m: got %h, expected 0", wb.dat_m); end
        if ({tx_valid, tx_data} !== 9'd0) begin errors++; $display("FAIL reset_tx: valid=%b data=%h, expected 0/00", tx_valid, tx_data); end
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b, expected 1", rx_ready); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_write_read;
        cfg_stall = 0; cfg_lat = 1;
        run_frame(8'h01, 32'h10, 32'hDEADBEEF, M_OK);
        checks += 2;
        if (got_q.size() !== exp_q.size() || pk(got_q) !== pk(exp_q)) begin errors++; $display("FAIL write_resp: got %0d bytes %h, expected %0d bytes %h", got_q.size(), pk(got_q), exp_q.size(), pk(exp_q)); end
        if ({acc_we, acc_sel, acc_adr, acc_dat} !== {1'b1, 4'hF, 32'h10, 32'hDEADBEEF}) begin errors++; $display("FAIL write_bus: we=%b sel=%h adr=%h dat=%h, expected 1 F 00000010 deadbeef", acc_we, acc_sel, acc_adr, acc_dat); end
        run_frame(8'h02, 32'h10, 32'h0, M_OK);
        checks += 2;
        if (got_q.size() !== 5 || pk(got_q) !== 40'hDEADBEEF00) begin errors++; $display("FAIL read_resp: got %0d bytes %h, expected 5 bytes deadbeef00", got_q.size(), pk(got_q)); end
        if ({acc_we, acc_sel, acc_adr} !== {1'b0, 4'hF, 32'h10}) begin errors++; $display("FAIL read_bus: we=%b sel=%h adr=%h, expected 0 F 00000010", acc_we, acc_sel, acc_adr); end
    endtask

    task automatic test_bad_cmd;
        int r0 = cyc_rises;
        run_frame(8'h7A, 32'h0, 32'h0, M_OK);
        checks += 2;
        if (got_q.size() !== exp_q.size() || pk(got_q) !== pk(exp_q)) begin errors++; $display("FAIL badcmd_resp: got %0d bytes %h, expected 1 byte ff", got_q.size(), pk(got_q)); end
        if (cyc_rises !== r0) begin errors++; $display("FAIL badcmd_cyc: %0d bus cycles, expected 0", cyc_rises - r0); end
        run_frame(8'h02, 32'h10, 32'h0, M_OK);
        checks++;
        if (got_q.size() !== exp_q.size() || pk(got_q) !== pk(exp_q)) begin errors++; $display("FAIL badcmd_next: got %0d bytes %h, expected %0d bytes %h", got_q.size(), pk(got_q), exp_q.size(), pk(exp_q)); end
    endtask

    task automatic test_stall;
        stable_viol = 0;
        cfg_stall = 3; cfg_lat = $urandom_range(0, 2);
        run_frame(8'h01, 32'h24, $urandom, M_OK);
        checks += 3;
        if (stb_len !== 4) begin errors++; $display("FAIL stall_stb: stb high %0d cycles, expected 4", stb_len); end
        if (cyc_len !== 4 + cfg_lat) begin errors++; $display("FAIL stall_cyc: cyc high %0d cycles, expected %0d", cyc_len, 4 + cfg_lat); end
        if (got_q.size() !== exp_q.size() || pk(got_q) !== pk(exp_q)) begin errors++; $display("FAIL stall_resp: got %0d bytes %h, expected %0d bytes %h", got_q.size(), pk(got_q), exp_q.size(), pk(exp_q)); end
        run_frame(8'h02, 32'h24, 32'h0, M_OK);
        checks += 2;
        if (got_q.size() !== exp_q.size() || pk(got_q) !== pk(exp_q)) begin errors++; $display("FAIL stall_read: got %0d bytes %h, expected %0d bytes %h", got_q.size(), pk(got_q), exp_q.size(), pk(exp_q)); end
        if (stable_viol !== 0) begin errors++; $display("FAIL stall_stable: %0d cycles with adr/dat_m changing under cyc, expected 0", stable_viol); end
        cfg_stall = 0;
    endtask

    task automatic test_bus_timeout;
        cfg_lat = 0;
        run_frame(8'h02, 32'h30, 32'h0, M_NORESP);
        checks += 2;
        if (cyc_len !== 16) begin errors++; $display("FAIL timeout_cyc: cyc high %0d cycles, expected 16", cyc_len); end
        if (got_q.size() !== 5 || pk(got_q) !== 40'h0000000002) begin errors++; $display("FAIL timeout_read: got %0d bytes %h, expected 5 bytes 0000000002", got_q.size(), pk(got_q)); end
        run_frame(8'h01, 32'h30, 32'h12345678, M_NORESP);
        checks++;
        if (got_q.size() !== 1 || pk(got_q) !== 40'h02) begin errors++; $display("FAIL timeout_write: got %0d bytes %h, expected 1 byte 02", got_q.size(), pk(got_q)); end
    endtask

    task automatic test_bus_error;
        cfg_lat = 2;
        run_frame(8'h02, 32'h34, 32'h0, M_ERR);
        checks++;
        if (got_q.size() !== 1 || pk(got_q) !== 40'h01) begin errors++; $display("FAIL err_read: got %0d bytes %h, expected 1 byte 01", got_q.size(), pk(got_q)); end
        cfg_lat = 0;
        run_frame(8'h01, 32'h38, 32'hA5A55A5A, M_ERR);
        checks++;
        if (got_q.size() !== 1 || pk(got_q) !== 40'h01) begin errors++; $display("FAIL err_zero_wait: got %0d bytes %h, expected 1 byte 01", got_q.size(), pk(got_q)); end
    endtask

    task automatic test_frame_timeout;
        int r0 = cyc_rises;
        got_q = {};
        cfg_mode = M_OK;
        send_byte(8'h02); send_byte(8'h34); send_byte(8'h12);
        repeat (60) @(posedge clk);
        #1;
        checks += 2;
        if (got_q.size() !== 0 || cyc_rises !== r0) begin errors++; $display("FAIL frame_timeout_silent: %0d tx bytes, %0d bus cycles, expected 0 and 0", got_q.size(), cyc_rises - r0); end
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL frame_timeout_ready: rx_ready=%b, expected 1", rx_ready); end
        run_frame(8'h02, 32'h10, 32'h0, M_OK);
        checks++;
        if (got_q.size() !== exp_q.size() || pk(got_q) !== pk(exp_q)) begin errors++; $display("FAIL frame_timeout_next: got %0d bytes %h, expected %0d bytes %h", got_q.size(), pk(got_q), exp_q.size(), pk(exp_q)); end
    endtask

    task automatic test_tx_backpressure;
        int k = 0;
        hold_viol = 0;
        cfg_mode = M_OK; cfg_lat = 1;
        got_q = {};
        model_frame(8'h02, 32'h24, 32'h0, M_OK);
        send_frame(8'h02, 32'h24, 32'h0);
        while (got_q.size() < 1 && k < 200) begin @(posedge clk); k++; end
        tx_block = 10;
        wait_resp(5);
        checks += 2;
        if (got_q.size() !== exp_q.size() || pk(got_q) !== pk(exp_q)) begin errors++; $display("FAIL backpressure_resp: got %0d bytes %h, expected %0d bytes %h", got_q.size(), pk(got_q), exp_q.size(), pk(exp_q)); end
        if (hold_viol !== 0) begin errors++; $display("FAIL backpressure_hold: %0d stalled cycles changed tx, expected 0", hold_viol); end
    endtask

    task automatic test_random;
        logic [7:0] cmd;
        int mode;
        for (int n = 0; n < 30; n++) begin
            cmd = $urandom_range(0, 9) == 0 ? 8'($urandom) : ($urandom_range(0, 1) ? 8'h01 : 8'h02);
            if (cmd == 8'h01 || cmd == 8'h02) cmd = cmd;
            mode = $urandom_range(0, 9) < 6 ? M_OK : $urandom_range(1, 2);
            cfg_stall = $urandom_range(0, 3);
            cfg_lat = $urandom_range(0, 3);
            run_frame(cmd, $urandom, $urandom, mode);
            checks++;
            if (got_q.size() !== exp_q.size() || pk(got_q) !== pk(exp_q)) begin errors++; $display("FAIL random_%0d cmd=%h mode=%0d: got %0d bytes %h, expected %0d bytes %h", n, cmd, mode, got_q.size(), pk(got_q), exp_q.size(), pk(exp_q)); end
        end
        cfg_stall = 0;
    endtask

    task automatic test_reset_mid;
        int k = 0, r0;
        cfg_mode = M_NORESP; cfg_lat = 0;
        got_q = {};
        send_frame(8'h02, 32'h44, 32'h0);
        while (!wb.cyc && k < 20) begin @(posedge clk); #1; k++; end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if ({wb.cyc, wb.stb, tx_valid} !== 3'b000) begin errors++; $display("FAIL midreset_outputs: cyc=%b stb=%b tx_valid=%b, expected 000", wb.cyc, wb.stb, tx_valid); end
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL midreset_rx_ready: got %b, expected 1", rx_ready); end
        @(negedge clk) rst_n = 1'b1;
        r0 = cyc_rises;
        repeat (30) @(posedge clk);
        checks++;
        if (got_q.size() !== 0 || cyc_rises !== r0) begin errors++; $display("FAIL midreset_silent: %0d tx bytes, %0d bus cycles, expected 0 and 0", got_q.size(), cyc_rises - r0); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = $urandom;
            model_mem[i] = slave_mem[i];
        end
        test_reset;
        test_write_read;
        test_bad_cmd;
        test_stall;
        test_bus_timeout;
        test_bus_error;
        test_frame_timeout;
        test_tx_backpressure;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
